// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus sequencer: mode encoding, operand and
// sweep-count widths, and small helpers used by the mode FSM.
package stim_pkg;

  localparam int AB_W    = 2;
  localparam int SWEEP_W = 4;
  localparam logic [SWEEP_W-1:0] SWEEP_MAX = SWEEP_W'(15);

  typedef enum logic [1:0] {
    MODE_SWITCH = 2'd0,
    MODE_STEP   = 2'd1,
    MODE_AUTO   = 2'd2
  } mode_e;

  // Mode rotation on each accepted mode press.
  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      MODE_SWITCH: next_mode = MODE_STEP;
      MODE_STEP:   next_mode = MODE_AUTO;
      default:     next_mode = MODE_SWITCH;
    endcase
  endfunction

  // Saturating sweep counter increment.
  function automatic logic [SWEEP_W-1:0] sweep_inc(input logic [SWEEP_W-1:0] cnt);
    sweep_inc = (cnt == SWEEP_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchronizer, run-length debounce and a
// one-cycle pulse when the debounced level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES
  // consecutive cycles; any return to the old level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_b != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_b;
          cnt   <= '0;
          press <= sync_b;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stimulus_sequencer.sv
// Operand-pair stimulus source for a gate-array demo: follows switches,
// steps manually, or sweeps automatically through 00->01->10->11.
module stimulus_sequencer
  import stim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_DIV        = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_step,
  input  logic               btn_mode,
  input  logic [AB_W-1:0]    sw_ab,
  output logic [AB_W-1:0]    ab_out,
  output logic               ab_valid,
  output logic [1:0]         mode,
  output logic [SWEEP_W-1:0] sweep_count
);

  localparam int PW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  logic               step_press;
  logic               mode_press;
  logic [AB_W-1:0]    sw_a;
  logic [AB_W-1:0]    sw_b;

  mode_e              mode_q,  mode_d;
  logic [AB_W-1:0]    ab_q,    ab_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               valid_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_step),
    .press (step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .press (mode_press)
  );

  // Switches are synchronized but deliberately not debounced.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_a <= '0;
      sw_b <= '0;
    end else begin
      sw_a <= sw_ab;
      sw_b <= sw_a;
    end
  end

  // Mode FSM and operand sequencing; a mode press pre-empts any step press.
  always_comb begin
    mode_d  = mode_q;
    ab_d    = ab_q;
    sweep_d = sweep_q;
    presc_d = presc_q;
    if (mode_press) begin
      mode_d  = next_mode(mode_q);
      sweep_d = '0;
      if (mode_d != MODE_SWITCH) begin
        ab_d    = '0;
        presc_d = '0;
      end
    end else begin
      case (mode_q)
        MODE_SWITCH: begin
          if (sw_b != ab_q) ab_d = sw_b;
        end
        MODE_STEP: begin
          if (step_press) begin
            ab_d = ab_q + 1'b1;
            if (ab_q == '1) sweep_d = sweep_inc(sweep_q);
          end
        end
        MODE_AUTO: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            ab_d    = ab_q + 1'b1;
            if (ab_q == '1) sweep_d = sweep_inc(sweep_q);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: mode_d = MODE_SWITCH;
      endcase
    end
  end

  // State registers; ab_valid flags every change of the registered pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_SWITCH;
      ab_q    <= '0;
      sweep_q <= '0;
      presc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      ab_q    <= ab_d;
      sweep_q <= sweep_d;
      presc_q <= presc_d;
      valid_q <= (ab_d != ab_q);
    end
  end

  assign ab_out      = ab_q;
  assign ab_valid    = valid_q;
  assign mode        = mode_q;
  assign sweep_count = sweep_q;

endmodule

// File: doc/stimulus_sequencer.md
STIMULUS_SEQUENCER -- requirements
Module: stimulus_sequencer

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a button level change.
REQ-002 SHALL provide parameter STEP_DIV, default 1024: clk cycles per automatic step, legal range 2..65536.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port btn_step, input, 1: raw, asynchronous manual-step pushbutton, active-high.
REQ-006 SHALL have port btn_mode, input, 1: raw, asynchronous mode-select pushbutton, active-high.
REQ-007 SHALL have port sw_ab, input, 2: raw, asynchronous operand switches; bit0=a, bit1=b.
REQ-008 SHALL have port ab_out, output, 2: registered operand pair driving the downstream gate-array inputs; bit0=a, bit1=b.
REQ-009 SHALL have port ab_valid, output, 1: one-cycle strobe asserted in the cycle ab_out takes a new value.
REQ-010 SHALL have port mode, output, 2: current mode; 0=SWITCH, 1=STEP, 2=AUTO; value 3 is never driven.
REQ-011 SHALL have port sweep_count, output, 4: number of completed truth-table sweeps, saturating.

Function
REQ-012 SHALL pass btn_step, btn_mode and each sw_ab bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each button: its debounced level takes the synchronized level after it has differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 SHALL generate a one-cycle press pulse in the cycle a debounced level rises 0->1; releases generate no event.
REQ-015 SHALL implement the mode FSM: SWITCH->STEP->AUTO->SWITCH, one transition per mode press.
REQ-016 SHALL, in SWITCH, load the synchronized sw_ab into ab_out whenever the two differ; latency is one cycle after the synchronizer output changes; switches are not debounced.
REQ-017 SHALL, in STEP, advance ab_out one position per step press through the sequence 00->01->10->11->00, effective the cycle after the press pulse.
REQ-018 SHALL, in AUTO, run a prescaler 0..STEP_DIV-1 and advance ab_out by one in the same sequence on each terminal count, then restart the prescaler at 0.
REQ-019 SHALL, on entering STEP or AUTO, force ab_out=00, clear the prescaler and clear sweep_count in the transition cycle.
REQ-020 SHALL, on entering SWITCH, clear sweep_count; ab_out then follows sw_ab per REQ-016.
REQ-021 SHALL increment sweep_count on each 11->00 wrap in STEP or AUTO, holding at 15 once reached.
REQ-022 SHALL ignore step presses in SWITCH and AUTO.
REQ-023 SHALL let a mode press win when mode and step presses occur in the same cycle; the step press is dropped.
REQ-024 SHALL assert ab_valid exactly when the registered ab_out value changes, including a forced clear to 00; no pulse when the value is unchanged.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, set: ab_out=00, ab_valid=0, mode=SWITCH, sweep_count=0, prescaler=0, debounce counters=0, debounced levels=0, synchronizer flops=0.
REQ-026 SHALL apply reset mid-operation, including mid-debounce or mid-prescale, with no pending event surviving; the first press is recognized only after a full debounce following rst deassertion.

Structure
REQ-027 SHALL define the mode encoding (SWITCH/STEP/AUTO), the sweep sequence width, and the SWEEP_MAX=15 constant in shared package stim_pkg.
REQ-028 SHALL implement synchronizer, debounce and press detection in one sub-module, btn_debounce, instantiated twice.
REQ-029 SHALL have the prescaler width derived from STEP_DIV via clog2; no other hard-coded widths.

Verification (bench parameters: DEBOUNCE_CYCLES=4, STEP_DIV=8)
REQ-030 SHALL cover: rst held 3 cycles then released with buttons idle -> ab_out=00, mode=0, sweep_count=0, ab_valid=0 for 20 cycles.
REQ-031 SHALL cover: mode held high 10 cycles -> mode=1, ab_out=00; then 5 step presses -> ab_out 01,10,11,00,01 with one ab_valid pulse per step and sweep_count=1.
REQ-032 SHALL cover: btn_step toggling every 2 cycles for 20 cycles in STEP -> no press accepted and ab_out unchanged.
REQ-033 SHALL cover: AUTO mode for 80 cycles -> ab_out advances every 8 cycles, sweep_count=2 after 64 cycles, ab_valid high 1 cycle per advance.
REQ-034 SHALL cover: mode and step presses aligned in the same cycle in STEP -> mode=2, ab_out=00, no step applied.
REQ-035 SHALL cover: SWITCH mode with sw_ab changed 00->10 -> ab_out=10 three cycles later plus one ab_valid pulse; rst asserted mid-AUTO -> all outputs return to REQ-025 values in the next cycle.
